// File: rtl/value_regs_pkg.sv
// ============================================================================
// Module : value_regs_pkg
// Brief  : Bit positions and 16-bit register types for the value register bank.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package value_regs_pkg;

    localparam int unsigned c_ST_RX_READY  = 0;
    localparam int unsigned c_ST_BO_THRESH = 1;
    localparam int unsigned c_ST_RX_ACTIVE = 8;
    localparam int unsigned c_ST_TX_ACTIVE = 9;

    localparam int unsigned c_ER_RX = 0;
    localparam int unsigned c_ER_TX = 8;

    typedef logic [15:0] status_t;
    typedef logic [15:0] error_t;

endpackage : value_regs_pkg

`default_nettype wire

// File: rtl/value_register_bank_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Saturating up-counter with synchronous clear; an increment in the
//          same cycle as a clear leaves the count at one.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_MAX = '1;
    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_count <= '0;
        end else if (i_inc) begin
            if (i_clr)
                r_count <= c_ONE;
            else if (r_count != c_MAX)
                r_count <= r_count + c_ONE;
        end else if (i_clr) begin
            r_count <= '0;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter

`default_nettype wire

// File: rtl/value_register_bank.sv
// ============================================================================
// Module : value_register_bank
// Brief  : AHB-visible status/error/occupancy/EHTS registers for the USB-AHB
//          bridge. Optional feature macro: STICKY_ERR_EN (sticky error bits).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module value_register_bank
    import value_regs_pkg::*;
#(
    parameter int BO_WIDTH      = 7,
    parameter int EHTS_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 4,
    parameter int BO_THRESH     = 48
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic                     rxDataReady,
    input  logic                     rxTransferActive,
    input  logic                     txTransferActive,
    input  logic                     rxError,
    input  logic                     txError,
    input  logic [BO_WIDTH-1:0]      bufferOccupancy,
    input  logic [EHTS_WIDTH-1:0]    nextEHTSData,
    input  logic                     ehtsLoad,
    input  logic                     errClear,
    input  logic                     boMaxClear,
    input  logic [1:0]               irqEnable,
    output logic [15:0]              statusData,
    output logic [15:0]              errorData,
    output logic [7:0]               boData,
    output logic [7:0]               boMaxData,
    output logic [7:0]               ehtsData,
    output logic [ERR_CNT_WIDTH-1:0] rxErrCount,
    output logic [ERR_CNT_WIDTH-1:0] txErrCount,
    output logic                     irq
);

    localparam logic [BO_WIDTH-1:0] c_BO_THRESH = BO_WIDTH'(BO_THRESH);

    status_t               r_status;
    error_t                r_error;
    logic [BO_WIDTH-1:0]   r_bo;
    logic [BO_WIDTH-1:0]   r_bo_max;
    logic [EHTS_WIDTH-1:0] r_ehts;
    logic                  r_irq;

    status_t w_status_next;
    error_t  w_error_next;

    always_comb begin
        w_status_next                 = '0;
        w_status_next[c_ST_RX_READY]  = rxDataReady;
        w_status_next[c_ST_BO_THRESH] = (bufferOccupancy >= c_BO_THRESH);
        w_status_next[c_ST_RX_ACTIVE] = rxTransferActive;
        w_status_next[c_ST_TX_ACTIVE] = txTransferActive;
    end

    always_comb begin
        w_error_next = '0;
`ifdef STICKY_ERR_EN
        // A new error event in the clear cycle keeps its bit set.
        w_error_next[c_ER_RX] = rxError | (r_error[c_ER_RX] & ~errClear);
        w_error_next[c_ER_TX] = txError | (r_error[c_ER_TX] & ~errClear);
`else
        w_error_next[c_ER_RX] = rxError;
        w_error_next[c_ER_TX] = txError;
`endif
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_status <= '0;
            r_error  <= '0;
            r_bo     <= '0;
            r_bo_max <= '0;
            r_ehts   <= '0;
            r_irq    <= '0;
        end else begin
            r_status <= w_status_next;
            r_error  <= w_error_next;
            r_bo     <= bufferOccupancy;
            if (boMaxClear || (bufferOccupancy > r_bo_max))
                r_bo_max <= bufferOccupancy;
            if (ehtsLoad)
                r_ehts <= nextEHTSData;
            // Interrupt trails the registered status/error it reflects by one cycle.
            r_irq <= (irqEnable[0] & (|r_error)) |
                     (irqEnable[1] & r_status[c_ST_RX_READY]);
        end
    end

    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_rx_cnt (
        .clk     (clk),
        .nRst    (nRst),
        .i_inc   (rxError),
        .i_clr   (errClear),
        .o_count (rxErrCount)
    );

    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_tx_cnt (
        .clk     (clk),
        .nRst    (nRst),
        .i_inc   (txError),
        .i_clr   (errClear),
        .o_count (txErrCount)
    );

    assign statusData = r_status;
    assign errorData  = r_error;
    assign boData     = 8'(r_bo);
    assign boMaxData  = 8'(r_bo_max);
    assign ehtsData   = 8'(r_ehts);
    assign irq        = r_irq;

endmodule : value_register_bank

`default_nettype wire

// File: tb/tb_value_register_bank.sv
// ============================================================================
// Module : tb_value_register_bank
// Brief  : Directed self-checking bench for value_register_bank (default params).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_value_register_bank;

    logic       clk = 1'b0;
    logic       nRst;
    logic       rxDataReady, rxTransferActive, txTransferActive;
    logic       rxError, txError, ehtsLoad, errClear, boMaxClear;
    logic [6:0] bufferOccupancy;
    logic [7:0] nextEHTSData;
    logic [1:0] irqEnable;
    logic [15:0] statusData, errorData;
    logic [7:0] boData, boMaxData, ehtsData;
    logic [3:0] rxErrCount, txErrCount;
    logic       irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    value_register_bank dut (
        .clk              (clk),
        .nRst             (nRst),
        .rxDataReady      (rxDataReady),
        .rxTransferActive (rxTransferActive),
        .txTransferActive (txTransferActive),
        .rxError          (rxError),
        .txError          (txError),
        .bufferOccupancy  (bufferOccupancy),
        .nextEHTSData     (nextEHTSData),
        .ehtsLoad         (ehtsLoad),
        .errClear         (errClear),
        .boMaxClear       (boMaxClear),
        .irqEnable        (irqEnable),
        .statusData       (statusData),
        .errorData        (errorData),
        .boData           (boData),
        .boMaxData        (boMaxData),
        .ehtsData         (ehtsData),
        .rxErrCount       (rxErrCount),
        .txErrCount       (txErrCount),
        .irq              (irq)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        nRst = 1'b0;
        rxDataReady = 0; rxTransferActive = 0; txTransferActive = 0;
        rxError = 0; txError = 0; ehtsLoad = 0; errClear = 0; boMaxClear = 0;
        bufferOccupancy = '0; nextEHTSData = '0; irqEnable = 2'b00;
        step(2);
        check("rst_status", 32'(statusData), 32'h0);
        check("rst_error",  32'(errorData),  32'h0);
        check("rst_irq",    32'(irq),        32'h0);
        nRst = 1'b1;

        // traffic, then asynchronous reset mid-operation
        rxError = 1; txError = 1; bufferOccupancy = 7'h50; rxDataReady = 1;
        nextEHTSData = 8'h77; ehtsLoad = 1; irqEnable = 2'b11;
        step(3);
        check("pre_rst_rxcnt", 32'(rxErrCount), 32'd3);
        nRst = 1'b0;
        #1;
        check("midrst_status", 32'(statusData), 32'h0);
        check("midrst_error",  32'(errorData),  32'h0);
        check("midrst_rxcnt",  32'(rxErrCount), 32'h0);
        check("midrst_txcnt",  32'(txErrCount), 32'h0);
        check("midrst_bomax",  32'(boMaxData),  32'h0);
        check("midrst_ehts",   32'(ehtsData),   32'h0);
        check("midrst_irq",    32'(irq),        32'h0);
        rxError = 0; txError = 0; bufferOccupancy = '0; rxDataReady = 0;
        nextEHTSData = '0; ehtsLoad = 0; irqEnable = 2'b00;
        step(1);
        nRst = 1'b1;

        // status register
        rxDataReady = 1; txTransferActive = 1;
        step(2);
        check("status_0201", 32'(statusData), 32'h0201);
        check("irq_disabled", 32'(irq), 32'h0);
        rxDataReady = 0; txTransferActive = 0; rxTransferActive = 1;
        step(1);
        check("status_0100", 32'(statusData), 32'h0100);
        rxTransferActive = 0;

        // saturating rx error counter
        rxError = 1;
        step(20);
        check("rxcnt_sat", 32'(rxErrCount), 32'd15);
        check("err_rx_level", 32'(errorData), 32'h0001);
        rxError = 0; errClear = 1;
        step(1);
        check("rxcnt_clr", 32'(rxErrCount), 32'd0);
        rxError = 1; errClear = 1;
        step(1);
        check("rxcnt_evt_wins", 32'(rxErrCount), 32'd1);
        rxError = 0; errClear = 0;
        step(1);
        check("rxcnt_hold", 32'(rxErrCount), 32'd1);
`ifdef STICKY_ERR_EN
        check("err_sticky_setwins", 32'(errorData), 32'h0001);
`else
        check("err_legacy_drop", 32'(errorData), 32'h0000);
`endif
        errClear = 1;
        step(1);
        errClear = 0;
        check("err_after_clr", 32'(errorData), 32'h0000);

        // single-cycle error pulses
        rxError = 1;
        step(1);
        rxError = 0; txError = 1;
        step(1);
        txError = 0;
        step(1);
`ifdef STICKY_ERR_EN
        check("err_pulses", 32'(errorData), 32'h0101);
        step(1);
        check("err_pulses_held", 32'(errorData), 32'h0101);
`else
        check("err_pulses", 32'(errorData), 32'h0000);
        step(1);
        check("err_pulses_held", 32'(errorData), 32'h0000);
`endif
        check("txcnt_one", 32'(txErrCount), 32'd1);
        errClear = 1;
        step(1);
        errClear = 0;
        check("err_pulses_clr", 32'(errorData), 32'h0000);
        check("txcnt_clr", 32'(txErrCount), 32'd0);

        // occupancy, threshold and high-water mark
        bufferOccupancy = 7'h12;
        step(1);
        check("bo_12", 32'(boData), 32'h12);
        check("thr_12", 32'(statusData), 32'h0000);
        bufferOccupancy = 7'h40;
        step(1);
        check("thr_40", 32'(statusData), 32'h0002);
        bufferOccupancy = 7'h01;
        step(1);
        check("bo_01", 32'(boData), 32'h01);
        check("bomax_40", 32'(boMaxData), 32'h40);
        check("thr_01", 32'(statusData), 32'h0000);
        boMaxClear = 1;
        step(1);
        boMaxClear = 0;
        check("bomax_clr", 32'(boMaxData), 32'h01);
        bufferOccupancy = 7'd48;
        step(1);
        check("thr_eq48", 32'(statusData), 32'h0002);
        bufferOccupancy = 7'd47;
        step(1);
        check("thr_47", 32'(statusData), 32'h0000);
        check("bomax_48", 32'(boMaxData), 32'd48);
        bufferOccupancy = 7'h05; boMaxClear = 1;
        step(1);
        boMaxClear = 0;
        check("bomax_clr_wins", 32'(boMaxData), 32'h05);

        // EHTS capture
        nextEHTSData = 8'h3A; ehtsLoad = 0;
        step(1);
        check("ehts_noload", 32'(ehtsData), 32'h00);
        ehtsLoad = 1;
        step(1);
        ehtsLoad = 0; nextEHTSData = 8'h55;
        check("ehts_load", 32'(ehtsData), 32'h3A);
        step(1);
        check("ehts_hold", 32'(ehtsData), 32'h3A);

        // interrupts
        irqEnable = 2'b01; txError = 1;
        step(1);
        txError = 0;
        check("irq_err_data", 32'(errorData), 32'h0100);
        check("irq_err_lag", 32'(irq), 32'h0);
        step(1);
        check("irq_err", 32'(irq), 32'h1);
        step(1);
`ifdef STICKY_ERR_EN
        check("irq_err_after", 32'(irq), 32'h1);
`else
        check("irq_err_after", 32'(irq), 32'h0);
`endif
        irqEnable = 2'b10; rxDataReady = 1; errClear = 1;
        step(1);
        errClear = 0;
        check("irq_rx_lag", 32'(irq), 32'h0);
        step(1);
        check("irq_rx", 32'(irq), 32'h1);
        rxDataReady = 0;
        step(2);
        check("irq_rx_drop", 32'(irq), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_value_register_bank

`default_nettype wire
